// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : RV32I write-back stage: MEM/WB register, 32x32 register file with
//            same-cycle write-through read ports, forwarding and retire count.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int MEM_WB_BUS = 38,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_WB_BUS-1:0] mem_wb_bus_in,
  input  logic                  mem_wb_valid,
  input  logic                  wb_stall,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic [31:0]           rs1_data,
  output logic [31:0]           rs2_data,
  output logic [4:0]            wb_fwd_rd,
  output logic                  wb_fwd_wen,
  output logic [31:0]           wb_fwd_data,
  output logic [CNT_W-1:0]      retire_cnt
);

  localparam int         C_DATA_LSB = 0;
  localparam int         C_WEN_BIT  = 32;
  localparam int         C_RD_LSB   = 33;
  localparam logic [4:0] C_X0       = 5'd0;

  logic              valid_q,   valid_d;
  logic [4:0]        rd_q,      rd_d;
  logic              rd_wen_q,  rd_wen_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic [31:0]       regs_q [32];

  logic              w_fire;
  logic              w_rf_we;

  // A stalled stage keeps its instruction; the producer must hold its bus.
  always_comb begin
    valid_d   = valid_q;
    rd_d      = rd_q;
    rd_wen_d  = rd_wen_q;
    wb_data_d = wb_data_q;
    if (!wb_stall) begin
      valid_d   = mem_wb_valid;
      rd_d      = mem_wb_bus_in[C_RD_LSB +: 5];
      rd_wen_d  = mem_wb_bus_in[C_WEN_BIT];
      wb_data_d = mem_wb_bus_in[C_DATA_LSB +: 32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rd_q      <= 5'd0;
      rd_wen_q  <= 1'b0;
      wb_data_q <= 32'd0;
    end else begin
      valid_q   <= valid_d;
      rd_q      <= rd_d;
      rd_wen_q  <= rd_wen_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign w_fire  = valid_q & ~wb_stall;
  assign w_rf_we = w_fire & rd_wen_q & (rd_q != C_X0);

  // Entry 0 is cleared on reset and never written, so x0 stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (w_rf_we) begin
      regs_q[rd_q] <= wb_data_q;
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    logic [31:0] data;
    data = regs_q[addr];
    if (addr == C_X0) begin
      data = 32'd0;
    end else if (w_rf_we && (addr == rd_q)) begin
      data = wb_data_q;
    end
    return data;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (w_fire) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign wb_fwd_rd   = rd_q;
  assign wb_fwd_data = wb_data_q;
  assign wb_fwd_wen  = w_rf_we;
  assign retire_cnt  = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// tb_wb_stage: directed stimulus with a commit scoreboard checked by a
// monitor on the falling edge, plus direct checks of reads and counts.
module tb_wb_stage;

  localparam int MEM_WB_BUS = 38;
  localparam int CNT_W      = 64;

  logic                  clk;
  logic                  rst;
  logic [MEM_WB_BUS-1:0] mem_wb_bus_in;
  logic                  mem_wb_valid;
  logic                  wb_stall;
  logic [4:0]            rs1_addr;
  logic [4:0]            rs2_addr;
  logic [31:0]           rs1_data;
  logic [31:0]           rs2_data;
  logic [4:0]            wb_fwd_rd;
  logic                  wb_fwd_wen;
  logic [31:0]           wb_fwd_data;
  logic [CNT_W-1:0]      retire_cnt;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  wb_stage #(.MEM_WB_BUS(MEM_WB_BUS), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wb_bus_in(mem_wb_bus_in),
    .mem_wb_valid (mem_wb_valid),
    .wb_stall     (wb_stall),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .wb_fwd_rd    (wb_fwd_rd),
    .wb_fwd_wen   (wb_fwd_wen),
    .wb_fwd_data  (wb_fwd_data),
    .retire_cnt   (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every commit the DUT announces must match the oldest expected commit.
  always @(negedge clk) begin
    if (!rst && wb_fwd_wen) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_commit: got rd=%0d data=%h expected none", wb_fwd_rd, wb_fwd_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit_rd", 64'(wb_fwd_rd), 64'(mon_e.rd));
        check("commit_data", 64'(wb_fwd_data), 64'(mon_e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_wb_valid  = 1'b0;
    mem_wb_bus_in = '0;
  endtask

  // Present one bus word for one edge; it sits in the stage on return.
  task automatic issue(input logic [4:0] rd, input logic wen, input logic [31:0] data,
                       input logic valid, input logic expect_commit);
    mem_wb_bus_in = {rd, wen, data};
    mem_wb_valid  = valid;
    if (expect_commit) exp_q.push_back('{rd: rd, data: data});
    step();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    wb_stall = 1'b0;
    rs1_addr = 5'd5;
    rs2_addr = 5'd0;
    idle();
    step();
    step();
    check("reset_rs1", 64'(rs1_data), 64'h0);
    check("reset_fwd_wen", 64'(wb_fwd_wen), 64'h0);
    check("reset_cnt", retire_cnt, 64'h0);
    rst = 1'b0;

    // Basic commit
    issue(5'd5, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
    check("basic_fwd_wen", 64'(wb_fwd_wen), 64'h1);
    check("basic_fwd_rd", 64'(wb_fwd_rd), 64'd5);
    step();
    check("basic_read", 64'(rs1_data), 64'hDEADBEEF);
    check("basic_cnt", retire_cnt, 64'd1);

    // Bypass on both ports during the commit cycle
    rs1_addr = 5'd7;
    rs2_addr = 5'd7;
    #1;
    check("bypass_pre", 64'(rs1_data), 64'h0);
    issue(5'd7, 1'b1, 32'h12345678, 1'b1, 1'b1);
    check("bypass_rs1", 64'(rs1_data), 64'h12345678);
    check("bypass_rs2", 64'(rs2_data), 64'h12345678);
    step();
    check("bypass_cnt", retire_cnt, 64'd2);

    // x0 write is discarded but still retires
    rs1_addr = 5'd0;
    issue(5'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    check("x0_read", 64'(rs1_data), 64'h0);
    check("x0_fwd_wen", 64'(wb_fwd_wen), 64'h0);
    step();
    check("x0_cnt", retire_cnt, 64'd3);

    // Bubble with wen set
    rs1_addr = 5'd3;
    issue(5'd3, 1'b1, 32'h000000AA, 1'b0, 1'b0);
    check("bubble_fwd_wen", 64'(wb_fwd_wen), 64'h0);
    step();
    check("bubble_read", 64'(rs1_data), 64'h0);
    check("bubble_cnt", retire_cnt, 64'd3);

    // Stall for three edges while a competing bus word is presented
    rs1_addr = 5'd9;
    rs2_addr = 5'd10;
    issue(5'd9, 1'b1, 32'h00000055, 1'b1, 1'b1);
    wb_stall      = 1'b1;
    mem_wb_bus_in = {5'd10, 1'b1, 32'h00000066};
    mem_wb_valid  = 1'b1;
    #1;
    check("stall_fwd_wen", 64'(wb_fwd_wen), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_read", 64'(rs1_data), 64'h0);
      check("stall_cnt", retire_cnt, 64'd3);
      check("stall_hold_rd", 64'(wb_fwd_rd), 64'd9);
    end
    wb_stall = 1'b0;
    idle();
    #1;
    check("release_bypass", 64'(rs1_data), 64'h55);
    step();
    check("release_read", 64'(rs1_data), 64'h55);
    check("release_cnt", retire_cnt, 64'd4);
    check("stall_ignored_bus", 64'(rs2_data), 64'h0);

    // Counter wrap
    force dut.retire_cnt_q = {CNT_W{1'b1}};
    #1;
    release dut.retire_cnt_q;
    #1;
    check("wrap_deposit", retire_cnt, {CNT_W{1'b1}});
    issue(5'd11, 1'b1, 32'h00001234, 1'b1, 1'b1);
    step();
    check("wrap_cnt", retire_cnt, 64'd0);

    // Reset while an instruction is stalled in the stage
    rs1_addr = 5'd5;
    rs2_addr = 5'd4;
    issue(5'd4, 1'b1, 32'h00000099, 1'b1, 1'b0);
    wb_stall = 1'b1;
    step();
    check("pre_reset_rd", 64'(wb_fwd_rd), 64'd4);
    rst = 1'b1;
    #1;
    check("rst_rs1", 64'(rs1_data), 64'h0);
    check("rst_rs2", 64'(rs2_data), 64'h0);
    check("rst_fwd_rd", 64'(wb_fwd_rd), 64'h0);
    check("rst_fwd_wen", 64'(wb_fwd_wen), 64'h0);
    check("rst_fwd_data", 64'(wb_fwd_data), 64'h0);
    check("rst_cnt", retire_cnt, 64'h0);
    step();
    rst      = 1'b0;
    wb_stall = 1'b0;
    step();
    check("post_rst_reg4", 64'(rs2_data), 64'h0);
    check("post_rst_cnt", retire_cnt, 64'h0);
    issue(5'd4, 1'b1, 32'h00000077, 1'b1, 1'b1);
    step();
    check("post_rst_write", 64'(rs2_data), 64'h77);
    check("post_rst_count", retire_cnt, 64'd1);

    step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
